// File: rtl/pixel_pkg.sv
// Shared pixel type, default 640x480@60 timing constants and test-pattern colour helper
// for the VGA controller.
package pixel_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pixel_t;

    localparam int unsigned COUNT_W = 10;

    localparam int unsigned DEFAULT_H_VISIBLE = 640;
    localparam int unsigned DEFAULT_H_FRONT   = 16;
    localparam int unsigned DEFAULT_H_SYNC    = 96;
    localparam int unsigned DEFAULT_H_BACK    = 48;
    localparam int unsigned DEFAULT_V_VISIBLE = 480;
    localparam int unsigned DEFAULT_V_FRONT   = 10;
    localparam int unsigned DEFAULT_V_SYNC    = 2;
    localparam int unsigned DEFAULT_V_BACK    = 33;

    localparam int unsigned H_TOTAL = DEFAULT_H_VISIBLE + DEFAULT_H_FRONT
                                    + DEFAULT_H_SYNC + DEFAULT_H_BACK;
    localparam int unsigned V_TOTAL = DEFAULT_V_VISIBLE + DEFAULT_V_FRONT
                                    + DEFAULT_V_SYNC + DEFAULT_V_BACK;

    localparam int unsigned BAR_W = 80;

    // Bar order: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic pixel_t bar_colour(input logic [2:0] bar);
        pixel_t p;
        p.red   = bar[1] ? 8'h00 : 8'hFF;
        p.green = bar[2] ? 8'h00 : 8'hFF;
        p.blue  = bar[0] ? 8'h00 : 8'hFF;
        return p;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider, horizontal/vertical counters and sync/visible decode.
module vga_timing
    import pixel_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEFAULT_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEFAULT_H_FRONT,
    parameter int unsigned H_SYNC    = DEFAULT_H_SYNC,
    parameter int unsigned H_BACK    = DEFAULT_H_BACK,
    parameter int unsigned V_VISIBLE = DEFAULT_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEFAULT_V_FRONT,
    parameter int unsigned V_SYNC    = DEFAULT_V_SYNC,
    parameter int unsigned V_BACK    = DEFAULT_V_BACK
) (
    input  logic               clock,
    input  logic               reset,
    output logic               target_clock,
    output logic [COUNT_W-1:0] h_count,
    output logic [COUNT_W-1:0] v_count,
    output logic               tick_c,
    output logic               h_visible_c,
    output logic               v_visible_c,
    output logic               h_sync_c,
    output logic               v_sync_c
);

    localparam int unsigned H_LAST     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1;
    localparam int unsigned V_LAST     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1;
    localparam int unsigned H_SYNC_BEG = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END = V_VISIBLE + V_FRONT + V_SYNC;

    // The tick is the edge on which target_clock falls, so it is high just before.
    assign tick_c = target_clock;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            target_clock <= 1'b0;
            h_count      <= '0;
            v_count      <= '0;
        end else begin
            target_clock <= !target_clock;
            if (tick_c) begin
                if (h_count == COUNT_W'(H_LAST)) begin
                    h_count <= '0;
                    v_count <= (v_count == COUNT_W'(V_LAST)) ? '0 : v_count + COUNT_W'(1);
                end else begin
                    h_count <= h_count + COUNT_W'(1);
                end
            end
        end
    end

    assign h_visible_c = (h_count < COUNT_W'(H_VISIBLE));
    assign v_visible_c = (v_count < COUNT_W'(V_VISIBLE));
    assign h_sync_c    = !((h_count >= COUNT_W'(H_SYNC_BEG)) && (h_count < COUNT_W'(H_SYNC_END)));
    assign v_sync_c    = !((v_count >= COUNT_W'(V_SYNC_BEG)) && (v_count < COUNT_W'(V_SYNC_END)));

endmodule

// File: rtl/vga_controller.sv
// VGA timing generator and registered pixel output stage.
// Define VGA_TEST_PATTERN_EN to replace frame-buffer data with eight colour bars.
module vga_controller
    import pixel_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEFAULT_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEFAULT_H_FRONT,
    parameter int unsigned H_SYNC    = DEFAULT_H_SYNC,
    parameter int unsigned H_BACK    = DEFAULT_H_BACK,
    parameter int unsigned V_VISIBLE = DEFAULT_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEFAULT_V_FRONT,
    parameter int unsigned V_SYNC    = DEFAULT_V_SYNC,
    parameter int unsigned V_BACK    = DEFAULT_V_BACK
) (
    input  logic               clock,
    input  logic               reset,
    input  pixel_t             data,
    output logic [COUNT_W-1:0] x_address,
    output logic [COUNT_W-1:0] y_address,
    output logic               target_clock,
    output logic               h_sync,
    output logic               v_sync,
    output logic               blank,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue
);

    logic [COUNT_W-1:0] h_count;
    logic [COUNT_W-1:0] v_count;
    logic               tick_c;
    logic               h_visible_c;
    logic               v_visible_c;
    logic               h_sync_c;
    logic               v_sync_c;
    logic               active_c;
    pixel_t             pixel_c;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clock        (clock),
        .reset        (reset),
        .target_clock (target_clock),
        .h_count      (h_count),
        .v_count      (v_count),
        .tick_c       (tick_c),
        .h_visible_c  (h_visible_c),
        .v_visible_c  (v_visible_c),
        .h_sync_c     (h_sync_c),
        .v_sync_c     (v_sync_c)
    );

    // Addresses park at zero outside the visible area.
    assign x_address = h_visible_c ? h_count : '0;
    assign y_address = v_visible_c ? v_count : '0;
    assign active_c  = h_visible_c && v_visible_c;

`ifdef VGA_TEST_PATTERN_EN
    assign pixel_c = bar_colour(3'(h_count / COUNT_W'(BAR_W)));
`else
    assign pixel_c = data;
`endif

    // Outputs lag the fetch address by one tick; syncs share the same delay.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_sync <= 1'b1;
            v_sync <= 1'b1;
            blank  <= 1'b0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else if (tick_c) begin
            h_sync <= h_sync_c;
            v_sync <= v_sync_c;
            blank  <= active_c;
            red    <= active_c ? pixel_c.red   : 8'h00;
            green  <= active_c ? pixel_c.green : 8'h00;
            blue   <= active_c ? pixel_c.blue  : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: a full-size instance for line timing and a shrunken
// instance for whole frames, both checked every clock against a position model.
module tb_vga_controller;
    import pixel_pkg::*;

    typedef struct packed {
        int hv; int hf; int hs; int hb; int vv; int vf; int vs; int vb;
    } cfg_t;

    typedef struct packed {
        logic        tclk;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        bl;
        logic [23:0] rgb;
    } exp_t;

    localparam cfg_t CFG_A = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam cfg_t CFG_B = '{20, 4, 6, 3, 12, 2, 2, 3};

    logic clk;
    logic rst_n;
    logic mode;
    logic [23:0] rnd_a, rnd_b;
    pixel_t data_a, data_b;

    logic [9:0] x_a, y_a, x_b, y_b;
    logic tclk_a, hs_a, vs_a, bl_a, tclk_b, hs_b, vs_b, bl_b;
    logic [7:0] r_a, g_a, b_a, r_b, g_b, b_b;

    int total = 0;
    int bad = 0;
    int edges = 0;
    logic [23:0] lat_a, lat_b;
    logic lat_m;

    int hs_fall_a, bl_rise_a, vs_fall_b, lines_b;
    logic prev_hs_a, prev_bl_a, prev_vs_b, prev_bl_b;

    assign data_a = mode ? pixel_t'({4'b0, y_a, x_a}) : pixel_t'(rnd_a);
    assign data_b = mode ? pixel_t'({4'b0, y_b, x_b}) : pixel_t'(rnd_b);

    vga_controller u_a (
        .clock(clk), .reset(rst_n), .data(data_a),
        .x_address(x_a), .y_address(y_a), .target_clock(tclk_a),
        .h_sync(hs_a), .v_sync(vs_a), .blank(bl_a),
        .red(r_a), .green(g_a), .blue(b_a)
    );

    vga_controller #(
        .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_b (
        .clock(clk), .reset(rst_n), .data(data_b),
        .x_address(x_b), .y_address(y_b), .target_clock(tclk_b),
        .h_sync(hs_b), .v_sync(vs_b), .blank(bl_b),
        .red(r_b), .green(g_b), .blue(b_b)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Expected outputs from the number of clocks since reset release.
    function automatic exp_t model(input cfg_t c, input bit in_rst, input int n_edges,
                                   input logic [23:0] lat, input bit lat_mode);
        logic [23:0] bars [8];
        exp_t e;
        int th, tv, ticks, a, q, qh, qv;
        bit act;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        e = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        if (in_rst) return e;
        th = c.hv + c.hf + c.hs + c.hb;
        tv = c.vv + c.vf + c.vs + c.vb;
        ticks = n_edges / 2;
        e.tclk = (n_edges % 2) == 1;
        a = ticks % (th * tv);
        e.x = ((a % th) < c.hv) ? 10'(a % th) : 10'd0;
        e.y = ((a / th) < c.vv) ? 10'(a / th) : 10'd0;
        if (ticks > 0) begin
            q = (ticks - 1) % (th * tv);
            qh = q % th;
            qv = q / th;
            act = (qh < c.hv) && (qv < c.vv);
            e.bl = act;
            e.hs = !((qh >= c.hv + c.hf) && (qh < c.hv + c.hf + c.hs));
            e.vs = !((qv >= c.vv + c.vf) && (qv < c.vv + c.vf + c.vs));
            if (act) begin
`ifdef VGA_TEST_PATTERN_EN
                e.rgb = bars[qh / 80];
`else
                e.rgb = lat_mode ? {4'b0, 10'(qv), 10'(qh)} : lat;
`endif
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        exp_t ea, eb;
        ea = model(CFG_A, !rst_n, edges, lat_a, lat_m);
        eb = model(CFG_B, !rst_n, edges, lat_b, lat_m);
        chk("a_tclk", 32'(tclk_a), 32'(ea.tclk));
        chk("a_x", 32'(x_a), 32'(ea.x));
        chk("a_y", 32'(y_a), 32'(ea.y));
        chk("a_hsync", 32'(hs_a), 32'(ea.hs));
        chk("a_vsync", 32'(vs_a), 32'(ea.vs));
        chk("a_blank", 32'(bl_a), 32'(ea.bl));
        chk("a_rgb", 32'({r_a, g_a, b_a}), 32'(ea.rgb));
        chk("b_tclk", 32'(tclk_b), 32'(eb.tclk));
        chk("b_x", 32'(x_b), 32'(eb.x));
        chk("b_y", 32'(y_b), 32'(eb.y));
        chk("b_hsync", 32'(hs_b), 32'(eb.hs));
        chk("b_vsync", 32'(vs_b), 32'(eb.vs));
        chk("b_blank", 32'(bl_b), 32'(eb.bl));
        chk("b_rgb", 32'({r_b, g_b, b_b}), 32'(eb.rgb));
    endtask

    task automatic clear_trackers();
        hs_fall_a = -1; bl_rise_a = -1; vs_fall_b = -1; lines_b = 0;
        prev_hs_a = 1'b1; prev_bl_a = 1'b0; prev_vs_b = 1'b1; prev_bl_b = 1'b0;
    endtask

    // Edge-to-edge intervals in clocks on the observed sync and blank outputs.
    task automatic measure();
        if (!prev_bl_a && bl_a) bl_rise_a = edges;
        if (prev_bl_a && !bl_a && bl_rise_a >= 0) chk("a_blank_width", 32'(edges - bl_rise_a), 32'd1280);
        if (prev_hs_a && !hs_a) begin
            if (hs_fall_a >= 0) chk("a_hsync_period", 32'(edges - hs_fall_a), 32'd1600);
            if (bl_rise_a >= 0) chk("a_hsync_after_blank", 32'(edges - bl_rise_a), 32'd1312);
            hs_fall_a = edges;
        end
        if (!prev_hs_a && hs_a && hs_fall_a >= 0) chk("a_hsync_low", 32'(edges - hs_fall_a), 32'd192);
        if (!prev_bl_b && bl_b) lines_b++;
        if (prev_vs_b && !vs_b) begin
            if (vs_fall_b >= 0) begin
                chk("b_vsync_period", 32'(edges - vs_fall_b), 32'd1254);
                chk("b_visible_lines", 32'(lines_b), 32'd12);
            end
            vs_fall_b = edges;
            lines_b = 0;
        end
        if (!prev_vs_b && vs_b && vs_fall_b >= 0) chk("b_vsync_low", 32'(edges - vs_fall_b), 32'd132);
        prev_hs_a = hs_a; prev_bl_a = bl_a; prev_vs_b = vs_b; prev_bl_b = bl_b;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if ((edges % 2) == 1) begin
                lat_a = rnd_a;
                lat_b = rnd_b;
                lat_m = mode;
            end
            edges++;
        end
        @(negedge clk);
        check_all();
        if (rst_n) measure();
        rnd_a = 24'($urandom);
        rnd_b = 24'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        mode = 1'b1;
        rnd_a = '0;
        rnd_b = '0;
        lat_a = '0;
        lat_b = '0;
        lat_m = 1'b1;
        clear_trackers();
        repeat (5) step();
        rst_n = 1'b1;

        // Address-echo data first, then random pixel data.
        repeat (3000) step();
        mode = 1'b0;
        repeat (2400) step();

        // Mid-frame reset: full-size instance is at line 3, pixel 300.
        rst_n = 1'b0;
        #1;
        edges = 0;
        check_all();
        clear_trackers();
        repeat (5) step();
        rst_n = 1'b1;
        repeat (3000) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_controller.md
Name: vga_controller

Overview:
- 640x480 @ 60 Hz VGA timing generator and pixel output stage.
- Divides the 50 MHz system clock by 2 to produce the 25 MHz pixel clock.
- Drives x/y fetch addresses to the frame buffer in the top level, which returns pixel data combinationally.
- Outputs registered RGB, syncs and blank toward the board's VGA DAC.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- data  in  24 (pixel_t)  pixel at current address; red is [23:16], green [15:8], blue [7:0]
- x_address  out  10  column being fetched
- y_address  out  10  line being fetched
- target_clock  out  1  pixel clock to the DAC (clock/2)
- h_sync  out  1  horizontal sync, active-low
- v_sync  out  1  vertical sync, active-low
- blank  out  1  active-high "display enable"; connects to DAC BLANK_N
- red  out  8  red channel
- green  out  8  green channel
- blue  out  8  blue channel

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports named clock and reset).
- Reset values: target_clock=0, h_count=0, v_count=0, h_sync=1, v_sync=1, blank=0, red/green/blue=0, x_address=0, y_address=0.
- target_clock toggles on every rising clock edge out of reset.
- Pixel tick is the clock edge on which target_clock goes 1->0. All counters and output registers update only on ticks.
- Consequence: outputs are stable around the DAC's rising-edge sampling point.
- h_count runs 0..799 (H_TOTAL = sum of H_*). At 799 it wraps to 0 and v_count increments.
- v_count runs 0..524 and wraps to 0 after 524.
- Addresses are combinational from the counters:
  - x_address = h_count when h_count < 640, else 0.
  - y_address = v_count when v_count < 480, else 0.
- Fetch: data is read combinationally in the same pixel period.
- Output registers, captured on each tick from the current counters and data:
  - active = (h_count < 640) && (v_count < 480).
  - blank <= active.
  - {red,green,blue} <= active ? data : 0.
  - h_sync <= !(656 <= h_count <= 751).
  - v_sync <= !(490 <= v_count <= 491).
- Latency: outputs lag the address by exactly one pixel tick (2 clocks). Syncs are delayed identically, so relative timing is preserved.
- Line length is 1600 clocks; h_sync low for 192 clocks. Frame length is 840000 clocks; v_sync low for 2 lines (3200 clocks).
- All sync boundaries derive from the parameters; the numbers above are the defaults.
- Reset mid-frame: all state returns immediately to reset values. The first tick after release restarts at pixel (0,0).
- x_address/y_address never exceed 639/479.

Optional Feature:
- Macro VGA_TEST_PATTERN_EN.
- When defined, data is ignored. The visible area shows 8 vertical bars, 80 px wide, selected by bar = h_count/80.
- Bar colours in order: white, yellow, cyan, green, magenta, red, blue, black (channels 8'hFF or 8'h00).
- Timing, addresses and blanking are unchanged.
- When undefined, data passes through as specified above.

Decomposition:
- Shared package pixel_pkg holds:
  - typedef pixel_t: packed struct {red, green, blue}, each logic [7:0].
  - Default timing constants and H_TOTAL/V_TOTAL.
- Optional sub-module vga_timing: counters, pixel tick, sync and active decode. The top keeps the output registers and data mux.

Test Plan:
- Reset: hold reset=0 for 5 clocks -> syncs=1, blank=0, RGB=0, addresses=0, target_clock=0. After release, target_clock toggles with a 2-clock period.
- Horizontal timing: measure h_sync -> period 1600 clocks, low width 192 clocks, falling edge 1312 clocks after blank rises at line start.
- Vertical timing: one full frame -> v_sync period 840000 clocks, low for 3200 clocks, 480 blank-high lines.
- Pass-through: data=24'hFF8040 constant -> red=FF, green=80, blue=40 while blank=1; all zero while blank=0.
- Address/latency: drive data={14'b0, x_address} -> red/green/blue at tick n equals the address from tick n-1. Last visible pixel shows x=639, y=479, then addresses are 0.
- Mid-frame reset at line 200, pixel 300 -> outputs return to reset values at once; first line after release starts at x=0, y=0.
